// File: rtl/mult_pkg.sv
// Shared widths, iteration count and FSM state type for the shift-add multiplier.
package mult_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;
  localparam int ITER   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_8.sv
// 8-bit ripple adder with carry in/out; the only adder in the multiplier datapath.
module adder_8
  import mult_pkg::*;
(
  input  logic [OP_W-1:0] x,
  input  logic [OP_W-1:0] y,
  input  logic            cin,
  output logic [OP_W-1:0] s,
  output logic            cout
);

  logic [OP_W:0] sum_full;

  assign sum_full = {1'b0, x} + {1'b0, y} + {{OP_W{1'b0}}, cin};
  assign s        = sum_full[OP_W-1:0];
  assign cout     = sum_full[OP_W];

endmodule

// File: rtl/shift_add_mult_8.sv
// Sequential 8x8 unsigned multiplier: one conditional add and right shift per cycle,
// valid/ready handshakes on both sides, product held until retired.
module shift_add_mult_8
  import mult_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product
);

  state_t              state_reg;
  logic [2:0]          cnt_reg;
  logic [OP_W-1:0]     mcand_reg;
  logic [OP_W-1:0]     acc_hi_reg;
  logic [OP_W-1:0]     acc_lo_reg;
  logic [PROD_W-1:0]   product_reg;

  logic [OP_W-1:0]     addend;
  logic [OP_W-1:0]     sum;
  logic                carry;
  logic [PROD_W-1:0]   shifted;

  assign addend = acc_lo_reg[0] ? mcand_reg : '0;

  adder_8 u_adder (
    .x    (acc_hi_reg),
    .y    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  // {carry,sum,acc_lo} >> 1: the carry lands in bit 15 so no overflow is lost
  assign shifted = {carry, sum, acc_lo_reg[OP_W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mcand_reg  <= a;
            acc_hi_reg <= '0;
            acc_lo_reg <= b;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          acc_hi_reg <= shifted[PROD_W-1:OP_W];
          acc_lo_reg <= shifted[OP_W-1:0];
          cnt_reg    <= cnt_reg + 3'd1;
          if (cnt_reg == 3'(ITER - 1)) begin
            product_reg <= shifted;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign product   = product_reg;

endmodule

// File: tb/tb_shift_add_mult_8.sv
// Self-checking bench: arithmetic reference model compared every cycle plus directed literal cases.
module tb_shift_add_mult_8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] product;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int prev_accept = -1;
  bit chk_en = 1'b0;

  // reference model state: busy countdown, then valid until retired
  logic        m_busy, m_valid;
  int          m_left;
  logic [15:0] m_pending, m_product;

  shift_add_mult_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_valid   <= 1'b0;
      m_left    <= 0;
      m_pending <= 16'h0;
      m_product <= 16'h0;
    end else if (!m_busy && !m_valid) begin
      if (in_valid) begin
        m_busy    <= 1'b1;
        m_left    <= 8;
        m_pending <= 16'(a) * 16'(b);
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy    <= 1'b0;
        m_valid   <= 1'b1;
        m_product <= m_pending;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", {31'b0, in_ready}, {31'b0, (!m_busy && !m_valid)});
      check("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("model_product", {16'b0, product}, {16'b0, m_product});
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp,
                        input int stall, input bit noise);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    if (prev_accept >= 0 && (cyc - prev_accept) < 10)
      check("initiation_interval", cyc - prev_accept, 10);
    prev_accept = cyc;
    if (noise) begin
      a = 8'hFF;
      b = 8'hFF;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, 8);
    check("product", {16'b0, product}, {16'b0, exp});
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_product", {16'b0, product}, {16'b0, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("retire_in_ready", {31'b0, in_ready}, 32'd1);
    check("retire_out_valid", {31'b0, out_valid}, 32'd0);
    check("hold_product", {16'b0, product}, {16'b0, exp});
  endtask

  task automatic directed(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp,
                          input int stall, input bit noise);
    run_op(ia, ib, exp, stall, noise);
    check("model_pin", {16'b0, m_product}, {16'b0, exp});
    $display("op a=%02h b=%02h product=%04h expected=%04h", ia, ib, product, exp);
  endtask

  initial begin
    #1;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_product", {16'b0, product}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    directed(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
    directed(8'h80, 8'h02, 16'h0100, 0, 1'b0);
    directed(8'h00, 8'hA5, 16'h0000, 0, 1'b0);
    directed(8'hA5, 8'h00, 16'h0000, 1, 1'b0);
    directed(8'h07, 8'h06, 16'h002A, 5, 1'b0);
    directed(8'h12, 8'h34, 16'h03A8, 2, 1'b1);

    // abandon an operation in RUN with an asynchronous reset
    in_valid = 1'b1;
    a = 8'h33;
    b = 8'h44;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_product", {16'b0, product}, 32'd0);
    check("async_in_ready", {31'b0, in_ready}, 32'd1);
    $display("reset mid-run: out_valid=%0b product=%04h in_ready=%0b", out_valid, product, in_ready);
    @(negedge clk);
    rst_n = 1'b1;
    prev_accept = -1;
    directed(8'h0F, 8'h0F, 16'h00E1, 0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)), 1'b0);
      if (k % 100 == 0)
        $display("random op %0d a=%02h b=%02h product=%04h", k, ra, rb, product);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_add_mult_8.md
SHIFT_ADD_MULT_8 -- requirements
Module: shift_add_mult_8

Interface
REQ-001 Parameters: none; all widths fixed at 8-bit operands and a 16-bit product.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept operands; equals (state==IDLE).
REQ-006 a  input  8  multiplicand, unsigned.
REQ-007 b  input  8  multiplier, unsigned.
REQ-008 out_valid  output  1  product valid; equals (state==DONE).
REQ-009 out_ready  input  1  downstream accepts product.
REQ-010 product  output  16  unsigned a*b, registered.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE, and no others.
REQ-012 IDLE: in_valid && in_ready at an edge captures mcand<=a, acc_hi<=0, acc_lo<=b and cnt<=0, then goes to RUN.
REQ-013 IDLE with in_valid low: registers hold and the state stays IDLE.
REQ-014 RUN, each cycle: {c,s} = acc_hi + (acc_lo[0] ? mcand : 0), with cin=0, via the 8-bit adder instance.
REQ-015 RUN, each cycle: {acc_hi,acc_lo} <= {c,s,acc_lo} >> 1, with the 17-bit carry kept through the shift so no overflow is lost.
REQ-016 RUN: cnt increments by 1 per cycle; the RUN cycle with cnt==7 SHALL go to DONE and load product<={c,s,acc_lo}>>1 (16 bits).
REQ-017 Latency: out_valid SHALL rise exactly 8 clock edges after the accepting edge.
REQ-018 in_valid, a and b SHALL be ignored in RUN and DONE; in_ready is 0 there.
REQ-019 DONE: product and out_valid SHALL hold stable while out_ready is 0, for any duration.
REQ-020 DONE with out_ready=1 at an edge: go to IDLE; in_ready rises in the following cycle.
REQ-021 There is no same-edge output-retire plus input-accept; minimum initiation interval is 10 cycles.
REQ-022 Operand 0 or 0xFF SHALL need no special-case path; the same 8 iterations always run.
REQ-023 product SHALL keep its last value in IDLE until the next DONE load.

Reset
REQ-024 rst_n low SHALL immediately, without waiting for clk, force state=IDLE, cnt=0, mcand=0, acc_hi=0, acc_lo=0 and product=0.
REQ-025 Output values during and after reset: out_valid=0, in_ready=1, product=0x0000.
REQ-026 Reset asserted mid-RUN or mid-DONE SHALL abandon the operation; no partial product ever appears on out_valid.
REQ-027 First acceptance is possible at the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package mult_pkg SHALL hold OP_W=8, PROD_W=16, ITER=8 and the state enum {IDLE,RUN,DONE}.
REQ-029 Exactly one sub-module SHALL be used: one adder_8 instance for the partial-sum add, with cin tied to 0 and cout feeding bit 16 of the shift.
REQ-030 The datapath SHALL be registers plus the one adder; no combinational multiplier and no second adder.

Verification
REQ-031 a=0xFF, b=0xFF accepted -> out_valid 8 edges later, product=0xFE01.
REQ-032 a=0x80, b=0x02 -> product=0x0100; a=0x00, b=0xA5 -> product=0x0000.
REQ-033 DONE with out_ready held 0 for 5 cycles -> product and out_valid stable throughout; retire on out_ready=1; in_ready=1 next cycle.
REQ-034 a=0x12, b=0x34 accepted, then a=0xFF, b=0xFF driven with in_valid=1 during RUN -> ignored, product=0x03A8.
REQ-035 rst_n pulsed low at RUN cycle 4 -> out_valid=0, product=0, in_ready=1 at once; new op a=0x0F, b=0x0F -> product=0x00E1.
REQ-036 Random a/b, 1000 ops with random out_ready stalls -> every product equals a*b; latency always 8; initiation interval always >=10.
